// File: rtl/core_ifetch.sv
// Instruction fetch unit: owns the PC and fetches one word per C_FETCH over a valid/ready read channel.
// Define IFETCH_BUSERR_EN to turn a non-OKAY M_RRESP into an ERR pulse with a NOP instruction.
module core_ifetch #(
   parameter logic [31:0] RESET_PC  = 32'h00000000,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        C_FETCH,
   input  logic        PC_LOAD,
   input  logic [31:0] PC_NEXT,
   output logic        M_ARVALID,
   output logic [31:0] M_ARADDR,
   input  logic        M_ARREADY,
   input  logic        M_RVALID,
   input  logic [31:0] M_RDATA,
   input  logic [1:0]  M_RRESP,
   output logic        M_RREADY,
   output logic [31:0] PC,
   output logic [31:0] INSTRUCTION,
   output logic [31:0] INSTR_PC,
   output logic        DONE,
   output logic        ERR,
   output logic        BUSY
);

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA
   } state_t;

   state_t      state;
   logic        load_seen;
   logic [31:0] fetch_addr;
   logic        bus_err;

   assign fetch_addr = PC_LOAD ? PC_NEXT : PC;

`ifdef IFETCH_BUSERR_EN
   assign bus_err = (M_RRESP != 2'b00);
`else
   logic unused_rresp;
   assign unused_rresp = ^M_RRESP;
   assign bus_err      = 1'b0;
`endif

   // A PC_LOAD seen while busy sticks in load_seen so the completion does not overwrite it.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= IDLE;
         load_seen   <= 1'b0;
         PC          <= RESET_PC;
         INSTRUCTION <= NOP_INSTR;
         INSTR_PC    <= RESET_PC;
         M_ARADDR    <= 32'h00000000;
         M_ARVALID   <= 1'b0;
         M_RREADY    <= 1'b0;
         DONE        <= 1'b0;
         ERR         <= 1'b0;
         BUSY        <= 1'b0;
      end else begin
         DONE <= 1'b0;
         ERR  <= 1'b0;
         case (state)
            IDLE: begin
               if (C_FETCH) begin
                  INSTR_PC <= fetch_addr;
                  if (fetch_addr[1:0] != 2'b00) begin
                     ERR         <= 1'b1;
                     INSTRUCTION <= NOP_INSTR;
                     PC          <= fetch_addr;
                  end else begin
                     M_ARADDR  <= fetch_addr;
                     M_ARVALID <= 1'b1;
                     BUSY      <= 1'b1;
                     load_seen <= 1'b0;
                     state     <= ADDR;
                  end
               end else if (PC_LOAD) begin
                  PC <= PC_NEXT;
               end
            end
            ADDR: begin
               if (PC_LOAD) begin
                  PC        <= PC_NEXT;
                  load_seen <= 1'b1;
               end
               if (M_ARREADY) begin
                  M_ARVALID <= 1'b0;
                  M_RREADY  <= 1'b1;
                  state     <= DATA;
               end
            end
            DATA: begin
               if (PC_LOAD) begin
                  PC        <= PC_NEXT;
                  load_seen <= 1'b1;
               end
               if (M_RVALID) begin
                  M_RREADY <= 1'b0;
                  BUSY     <= 1'b0;
                  state    <= IDLE;
                  if (bus_err) begin
                     INSTRUCTION <= NOP_INSTR;
                     ERR         <= 1'b1;
                     if (!PC_LOAD && !load_seen) begin
                        PC <= INSTR_PC;
                     end
                  end else begin
                     INSTRUCTION <= M_RDATA;
                     DONE        <= 1'b1;
                     if (!PC_LOAD && !load_seen) begin
                        PC <= INSTR_PC + 32'd4;
                     end
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_core_ifetch.sv
// Randomized bench for core_ifetch: a transaction-level PC/instruction model plus an in-bench memory responder.
module tb_core_ifetch;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        CLK = 1'b0;
   logic        RST;
   logic        C_FETCH;
   logic        PC_LOAD;
   logic [31:0] PC_NEXT;
   logic        M_ARVALID;
   logic [31:0] M_ARADDR;
   logic        M_ARREADY;
   logic        M_RVALID;
   logic [31:0] M_RDATA;
   logic [1:0]  M_RRESP;
   logic        M_RREADY;
   logic [31:0] PC;
   logic [31:0] INSTRUCTION;
   logic [31:0] INSTR_PC;
   logic        DONE;
   logic        ERR;
   logic        BUSY;

   int checkCount = 0;
   int failCount  = 0;

   logic [31:0] mPc;
   logic [31:0] mInstr;
   logic [31:0] mInstrPc;

   core_ifetch dut (
      .CLK(CLK), .RST(RST), .C_FETCH(C_FETCH), .PC_LOAD(PC_LOAD), .PC_NEXT(PC_NEXT),
      .M_ARVALID(M_ARVALID), .M_ARADDR(M_ARADDR), .M_ARREADY(M_ARREADY),
      .M_RVALID(M_RVALID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RREADY(M_RREADY),
      .PC(PC), .INSTRUCTION(INSTRUCTION), .INSTR_PC(INSTR_PC),
      .DONE(DONE), .ERR(ERR), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   // Contents of instruction memory, a fixed function of the word address.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (a == 32'h0) return 32'h00500093;
      return (a * 32'h9E3779B1) ^ 32'h0F0F1234;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic checkIdleState(input string tag);
      checkOutput({tag, "_pc"}, PC, mPc);
      checkOutput({tag, "_instr"}, INSTRUCTION, mInstr);
      checkOutput({tag, "_instr_pc"}, INSTR_PC, mInstrPc);
      checkOutput({tag, "_busy"}, 32'(BUSY), 32'd0);
      checkOutput({tag, "_arvalid"}, 32'(M_ARVALID), 32'd0);
      checkOutput({tag, "_rready"}, 32'(M_RREADY), 32'd0);
   endtask

   task automatic resetDut();
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      mPc = 32'h0;
      mInstr = NOP;
      mInstrPc = 32'h0;
      checkIdleState("reset");
      checkOutput("reset_araddr", M_ARADDR, 32'h0);
      checkOutput("reset_done", 32'(DONE), 32'd0);
      checkOutput("reset_err", 32'(ERR), 32'd0);
   endtask

   task automatic idleLoad(input logic [31:0] target);
      @(negedge CLK);
      PC_LOAD = 1'b1;
      PC_NEXT = target;
      @(negedge CLK);
      PC_LOAD = 1'b0;
      mPc = target;
      checkIdleState("idle_load");
   endtask

   // One complete fetch command; the bench plays memory with the given wait counts and
   // optionally pulses PC_LOAD (at busy cycle loadCycle) and stray C_FETCHes while busy.
   task automatic applyStimulus(input logic useLoad, input logic [31:0] target,
                                input int arWait, input int rWait, input int loadCycle,
                                input logic [31:0] busyTarget, input logic [1:0] resp,
                                input logic extraFetch);
      logic [31:0] addr;
      logic        busErr;
      logic        loaded;
      int          doneCycle;
      addr = useLoad ? target : mPc;
      @(negedge CLK);
      C_FETCH = 1'b1;
      PC_LOAD = useLoad;
      PC_NEXT = target;
      @(negedge CLK);
      C_FETCH = 1'b0;
      PC_LOAD = 1'b0;
      if (addr[1:0] != 2'b00) begin
         mPc = addr;
         mInstr = NOP;
         mInstrPc = addr;
         checkOutput("misalign_err", 32'(ERR), 32'd1);
         checkOutput("misalign_done", 32'(DONE), 32'd0);
         checkIdleState("misalign");
         @(negedge CLK);
         checkOutput("misalign_err_clear", 32'(ERR), 32'd0);
         checkOutput("misalign_no_arvalid", 32'(M_ARVALID), 32'd0);
         return;
      end
`ifdef IFETCH_BUSERR_EN
      busErr = (resp != 2'b00);
`else
      busErr = 1'b0;
`endif
      doneCycle = 3 + arWait + rWait;
      loaded = (loadCycle >= 1) && (loadCycle < doneCycle);
      for (int cyc = 1; cyc < doneCycle; cyc++) begin
         if (cyc <= arWait + 1) begin
            checkOutput("addr_arvalid", 32'(M_ARVALID), 32'd1);
            checkOutput("addr_araddr", M_ARADDR, addr);
            checkOutput("addr_rready", 32'(M_RREADY), 32'd0);
            M_ARREADY = (cyc == arWait + 1);
         end else begin
            checkOutput("data_rready", 32'(M_RREADY), 32'd1);
            checkOutput("data_arvalid", 32'(M_ARVALID), 32'd0);
            M_RVALID = (cyc == doneCycle - 1);
            M_RDATA  = M_RVALID ? memWord(addr) : $urandom;
            M_RRESP  = M_RVALID ? resp : 2'($urandom_range(0, 3));
         end
         checkOutput("busy_high", 32'(BUSY), 32'd1);
         checkOutput("done_early", 32'(DONE), 32'd0);
         PC_LOAD = (cyc == loadCycle);
         PC_NEXT = (cyc == loadCycle) ? busyTarget : $urandom;
         C_FETCH = extraFetch && (cyc % 2 == 1);
         @(negedge CLK);
         M_ARREADY = 1'b0;
         M_RVALID = 1'b0;
         PC_LOAD = 1'b0;
         C_FETCH = 1'b0;
         if (loaded && cyc == loadCycle && cyc < doneCycle - 1)
            checkOutput("busy_load_pc", PC, busyTarget);
      end
      mInstrPc = addr;
      mInstr = busErr ? NOP : memWord(addr);
      if (loaded) mPc = busyTarget;
      else mPc = busErr ? addr : addr + 32'd4;
      checkOutput("done_pulse", 32'(DONE), busErr ? 32'd0 : 32'd1);
      checkOutput("err_pulse", 32'(ERR), busErr ? 32'd1 : 32'd0);
      checkIdleState("complete");
      @(negedge CLK);
      checkOutput("done_single", 32'(DONE), 32'd0);
      checkOutput("err_single", 32'(ERR), 32'd0);
      checkOutput("no_second_txn", 32'(M_ARVALID), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] simulation timeout");
   end

   initial begin
      logic        useLoad;
      logic [31:0] target;
      logic [31:0] busyTarget;
      logic [1:0]  resp;
      int          arW;
      int          rW;
      int          lc;
      RST = 1'b1;
      C_FETCH = 1'b0;
      PC_LOAD = 1'b0;
      PC_NEXT = 32'h0;
      M_ARREADY = 1'b0;
      M_RVALID = 1'b0;
      M_RDATA = 32'h0;
      M_RRESP = 2'b00;
      repeat (2) @(negedge CLK);
      resetDut();

      // Zero-wait fetch at 0, then slow memory, then a PC_LOAD during DATA.
      applyStimulus(1'b0, 32'h0, 0, 0, 0, 32'h0, 2'b00, 1'b0);
      applyStimulus(1'b0, 32'h0, 3, 2, 0, 32'h0, 2'b00, 1'b0);
      applyStimulus(1'b1, 32'h8, 0, 1, 2, 32'h100, 2'b00, 1'b0);
      applyStimulus(1'b0, 32'h0, 0, 0, 0, 32'h0, 2'b00, 1'b0);
      checkOutput("after_load_instr_pc", INSTR_PC, 32'h100);

      // Misaligned target, PC wrap with stray C_FETCHes, bus error response.
      applyStimulus(1'b1, 32'h202, 0, 0, 0, 32'h0, 2'b00, 1'b0);
      applyStimulus(1'b1, 32'hFFFFFFFC, 1, 1, 0, 32'h0, 2'b00, 1'b1);
      checkOutput("pc_wrap", PC, 32'h0);
      applyStimulus(1'b1, 32'h10, 0, 0, 0, 32'h0, 2'b10, 1'b0);
      applyStimulus(1'b0, 32'h0, 1, 0, 3, 32'h40, 2'b00, 1'b0);

      // Reset in the middle of the address phase abandons the fetch.
      @(negedge CLK);
      C_FETCH = 1'b1;
      @(negedge CLK);
      C_FETCH = 1'b0;
      checkOutput("midreset_arvalid", 32'(M_ARVALID), 32'd1);
      resetDut();
      @(negedge CLK);
      checkOutput("midreset_hold_arvalid", 32'(M_ARVALID), 32'd0);

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 9) == 0) idleLoad($urandom & 32'hFFFFFFFC);
         useLoad = ($urandom_range(0, 3) == 0);
         target = $urandom;
         if ($urandom_range(0, 4) != 0) target[1:0] = 2'b00;
         arW = $urandom_range(0, 3);
         rW = $urandom_range(0, 3);
         lc = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4 + arW + rW) : 0;
         busyTarget = $urandom & 32'hFFFFFFFC;
         resp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         applyStimulus(useLoad, target, arW, rW, lc, busyTarget, resp, 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/core_ifetch.md
# core_ifetch

Instruction fetch unit for the RV32I core: on a one-cycle fetch command from the core controller it reads one 32-bit instruction word from instruction memory over a valid/ready read channel. It then presents the word, with its PC, to the instruction decode stage. It owns the program counter: it increments the PC on every completed fetch and accepts PC overrides from branch/jump resolution. It sits between the controller/instruction memory and the decode stage, producing the INSTRUCTION word that decode latches on C_DECODE.

## Interface
- Parameters:
  - RESET_PC, 32'h00000000, PC value loaded on reset.
  - NOP_INSTR, 32'h00000013, word driven on INSTRUCTION after reset and on a fetch error (addi x0,x0,0).
- Ports:
  - CLK  in  1  single clock; all logic on posedge.
  - RST  in  1  synchronous reset, active-high.
  - C_FETCH  in  1  fetch command pulse from controller.
  - PC_LOAD  in  1  load PC_NEXT into PC.
  - PC_NEXT  in  32  branch/jump target.
  - M_ARVALID  out  1  read address valid.
  - M_ARADDR  out  32  read address.
  - M_ARREADY  in  1  memory accepts address.
  - M_RVALID  in  1  read data valid.
  - M_RDATA  in  32  read data.
  - M_RRESP  in  2  read response (2'b00 = OKAY).
  - M_RREADY  out  1  fetch unit accepts data.
  - PC  out  32  current program counter.
  - INSTRUCTION  out  32  last fetched word, held until the next completed fetch.
  - INSTR_PC  out  32  address INSTRUCTION was fetched from.
  - DONE  out  1  one-cycle pulse: INSTRUCTION/INSTR_PC are new.
  - ERR  out  1  one-cycle pulse: fetch failed.
  - BUSY  out  1  high in any state except IDLE.

## Operation
- The FSM has three states: IDLE, ADDR, DATA.
- IDLE: C_FETCH=1 selects fetch address A = PC_LOAD ? PC_NEXT : PC.
  - If A[1:0] != 0: ERR pulses next cycle, INSTRUCTION <= NOP_INSTR, INSTR_PC <= A, PC <= A, and the FSM stays in IDLE.
  - Otherwise: M_ARADDR <= A, M_ARVALID <= 1, INSTR_PC <= A, go to ADDR.
- ADDR: M_ARVALID and M_ARADDR are held stable until M_ARREADY=1. On that cycle M_ARVALID <= 0, M_RREADY <= 1, go to DATA.
- DATA: wait for M_RVALID=1. On that cycle:
  - INSTRUCTION <= M_RDATA.
  - DONE pulses next cycle.
  - M_RREADY <= 0, go to IDLE.
  - PC <= INSTR_PC + 4, modulo 2^32 (0xFFFFFFFC wraps to 0).
- PC_LOAD while BUSY: PC <= PC_NEXT immediately. The fetch in flight completes normally and keeps its INSTR_PC. The completion increment is suppressed, so PC_NEXT is kept. PC_LOAD on the completion cycle also wins over the increment.
- PC_LOAD in IDLE without C_FETCH: PC <= PC_NEXT.
- C_FETCH while BUSY is ignored; no queueing.
- INSTRUCTION, INSTR_PC and PC change only as stated above.

## Timing
- Reset values:
  - PC=RESET_PC, INSTRUCTION=NOP_INSTR, INSTR_PC=RESET_PC, M_ARADDR=0.
  - M_ARVALID=0, M_RREADY=0, DONE=0, ERR=0, BUSY=0.
  - FSM in IDLE.
- Reset asserted mid-fetch: all values above apply on the next edge. The outstanding bus transaction is abandoned; memory is reset by the same RST.
- Minimum latency, zero-wait memory:
  - C_FETCH in cycle 0.
  - M_ARVALID high in cycle 1; with M_ARREADY in cycle 1, M_RREADY is high in cycle 2.
  - With M_RVALID in cycle 2, DONE and the new INSTRUCTION appear in cycle 3.
  - C_FETCH is accepted again in cycle 3.
- Each wait cycle on M_ARREADY or M_RVALID adds exactly one cycle.
- All outputs are registered. M_RDATA is sampled only when M_RREADY && M_RVALID.
- The controller asserts C_DECODE no earlier than the DONE cycle.

## Configuration
- IFETCH_BUSERR_EN defined: on the data handshake cycle, if M_RRESP != 2'b00:
  - INSTRUCTION <= NOP_INSTR.
  - ERR pulses instead of DONE.
  - PC is not incremented; it holds INSTR_PC, or PC_NEXT if PC_LOAD.
- IFETCH_BUSERR_EN undefined: M_RRESP is ignored and every data handshake completes with DONE. The misaligned-address ERR is always present in both builds.

## Test plan
- Reset then C_FETCH, zero-wait memory returning 0x00500093 at 0x0 -> DONE in cycle 3, INSTRUCTION=0x00500093, INSTR_PC=0, PC=4.
- M_ARREADY delayed 3 cycles, M_RVALID delayed 2 -> M_ARADDR stable throughout, DONE at cycle 8, exactly one DONE pulse.
- PC_LOAD with PC_NEXT=0x100 during DATA of a fetch at 0x8 -> INSTR_PC=0x8 at DONE, PC=0x100; next fetch reads 0x100.
- C_FETCH with PC_LOAD, PC_NEXT=0x202 -> ERR pulse next cycle, no M_ARVALID, INSTRUCTION=0x00000013, INSTR_PC=0x202.
- PC=0xFFFFFFFC fetch; C_FETCH during BUSY; RST during ADDR -> PC wraps to 0; extra C_FETCH causes no second transaction; after RST all outputs at reset values and BUSY=0.
- IFETCH_BUSERR_EN build, M_RRESP=2'b10 at PC=0x10 -> ERR pulse, no DONE, INSTRUCTION=0x00000013, PC=0x10; non-macro build -> DONE, PC=0x14.
